map_table: RTL and testbench
============================

Name: map_table

Overview:
- N-wide rename map table that sits directly downstream of free_list in the dispatch stage.
- Consumes the compacted free physical registers (free_list rd_reg) and produces fl_rd_num, which drives free_list rd_num.
- Translates arch sources and destinations to physical tags and reports Told for the ROB.
- Tracks per-physical-register ready bits from the CDB.
- Holds a circular stack of map checkpoints for early branch recovery.

Parameters:
- N, `N: superscalar width.
- ARCH_REG_SZ, `ARCH_REG_SZ: architectural registers; arch reg 0 is hardwired zero.
- PHYS_REG_SZ, `ARCH_REG_SZ+`ROB_SZ: physical registers.
- NUM_CHKPT, 4: checkpoint slots.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- rn_num  in  $clog2(N+1)  instructions renamed this cycle; slots 0..rn_num-1 valid
- rn_dest  in  [N][$clog2(ARCH_REG_SZ)]  dest arch reg; 0 = no dest
- rn_src1, rn_src2  in  [N][$clog2(ARCH_REG_SZ)]  source arch regs
- fl_reg  in  FREE_LIST_PACKET[N]  compacted free regs from free_list rd_reg
- fl_rd_num  out  $clog2(N+1)  count of valid slots with rn_dest!=0
- rn_src1_phys, rn_src2_phys  out  [N][$clog2(PHYS_REG_SZ)]  physical source tags
- rn_src1_rdy, rn_src2_rdy  out  [N]  source ready
- rn_dest_phys  out  [N][$clog2(PHYS_REG_SZ)]  new tag (T)
- rn_told  out  [N][$clog2(PHYS_REG_SZ)]  previous mapping (Told)
- cdb_valid  in  [N]  completion broadcast valid
- cdb_tag  in  [N][$clog2(PHYS_REG_SZ)]  completing physical tags
- br_save  in  1  take checkpoint this cycle
- br_save_slot  in  $clog2(N)  snapshot reflects slots 0..br_save_slot
- br_save_id  out  $clog2(NUM_CHKPT)  id assigned to this cycle's save
- br_en  in  1  mispredict: restore checkpoint
- br_restore_id  in  $clog2(NUM_CHKPT)  checkpoint to restore
- br_free  in  1  oldest checkpoint resolved correct; release it
- chkpt_full  out  1  all NUM_CHKPT in use; dispatch must not save

Behaviour:
- Rename is combinational, same cycle; map, ready and checkpoint updates are registered on posedge clock.
- Slots >= rn_num: all rn_* outputs are 0 and the slot has no effect. With reset asserted and rn_num=0, all rename outputs are 0.
- Allocation compaction: slot i with rn_dest!=0 takes fl_reg[k].reg_idx, where k = count of earlier valid slots with dest!=0. fl_rd_num = total such slots.
- Dest 0: rn_dest_phys=0, rn_told=0, map unchanged.
- Source lookup, in priority order:
  1. Nearest earlier slot j<i in the same group with rn_dest[j]==src and src!=0: tag = that slot's new tag, rdy=0.
  2. Otherwise: tag = map[src], rdy = ready[tag] OR (any cdb_valid with cdb_tag==tag) (same-cycle CDB bypass).
  3. src==0: tag 0, rdy 1.
- Told: same intra-group forwarding as sources; otherwise map[dest].
- Map write-back: for duplicate dests in one group, the youngest slot wins.
- Ready bits: set for every valid CDB tag; cleared for each newly allocated tag. Allocation clear beats CDB set on the same tag.
- Checkpoint stack: circular buffer with head (oldest), tail and count.
  - br_save with count<NUM_CHKPT: store the map as updated by slots 0..br_save_slot only, at tail; br_save_id=tail; tail++.
  - br_save while full: ignored.
  - chkpt_full = (count==NUM_CHKPT).
- br_en (highest priority):
  - map <= chkpt[br_restore_id].
  - tail <= br_restore_id; the restored and all younger checkpoints are released; count recomputed mod NUM_CHKPT from head.
  - This cycle's rename writes and br_save are ignored.
  - Ready bits are not restored; CDB updates still apply.
- br_free: head++, count--; ignored when count==0.
  - br_free + br_save in the same cycle: both take effect, count unchanged.
  - br_free + br_en: free applies first, then restore.
- Pointer wrap: modulo NUM_CHKPT.
- Reset (asynchronous): map[i]=i; ready all 1; head=tail=count=0; checkpoint contents 0. Reset taken mid-operation discards all state immediately.

Optional Feature:
- Macro MAP_TABLE_DEBUG_EN.
- Defined: adds outputs debug_map [ARCH_REG_SZ][$clog2(PHYS_REG_SZ)] (registered map), debug_ready [PHYS_REG_SZ], debug_chkpt_head, debug_chkpt_tail and debug_chkpt_count.
- Defined: simulation assertions that br_restore_id is a live checkpoint and that fl_reg[k].valid=1 for k<fl_rd_num.
- Undefined: the ports and assertions do not exist; functional behaviour is identical.

Decomposition:
- sys_defs.svh gains:
  - ARCH_REG_IDX, PHYS_REG_IDX, CHKPT_ID typedefs;
  - MAP_TABLE_T (ARCH_REG_SZ x PHYS_REG_IDX);
  - `PHYS_REG_SZ and `NUM_CHKPT constants.
- FREE_LIST_PACKET is reused unchanged.
- Sub-module map_chkpt_stack holds the circular checkpoint storage, pointers, count and full flag.

Test Plan:
- Reset then N=2, dest r1/r2, fl_reg={32,33}: src1 r1 -> phys 1 rdy 1; dest_phys {32,33}; told {1,2}; fl_rd_num 2.
- Slot0 dest r5 <- fl 40; slot1 src1 r5, dest r5: src1=40 rdy 0; slot1 told=40, dest=41; next cycle map[r5]=41.
- Phys 40 unready; cdb_valid[0]=1, cdb_tag=40 while slot0 src r5 (map 40) -> rdy 1 same cycle; ready[40]=1 next cycle.
- br_save slot0 (r3->50), slot1 dest r3->51; br_en id 0 next cycle -> map[r3]=50, chkpt count 0, concurrent rename ignored.
- 4 saves with no frees -> chkpt_full=1, 5th save ignored; br_free -> full=0, head=1; save -> id 0 (wrap).
- Dest r0 in slot0, r7 in slot1 -> fl_rd_num 1; slot1 gets fl_reg[0]; slot0 told 0. Reset mid-stream -> map identity, count 0.

Source files
------------

// File: rtl/map_table_pkg.sv
// Shared types and sizing for the rename map table and its checkpoint stack.
// Optional debug ports and checks are enabled by defining MAP_TABLE_DEBUG_EN.
package map_table_pkg;

    localparam int N           = 2;
    localparam int ARCH_REG_SZ = 32;
    localparam int ROB_SZ      = 32;
    localparam int PHYS_REG_SZ = ARCH_REG_SZ + ROB_SZ;
    localparam int NUM_CHKPT   = 4;

    localparam int ARCH_W  = $clog2(ARCH_REG_SZ);
    localparam int PHYS_W  = $clog2(PHYS_REG_SZ);
    localparam int CHKPT_W = $clog2(NUM_CHKPT);
    localparam int CNT_W   = $clog2(N + 1);
    localparam int SLOT_W  = (N > 1) ? $clog2(N) : 1;

    typedef logic [ARCH_W-1:0]  arch_reg_idx_t;
    typedef logic [PHYS_W-1:0]  phys_reg_idx_t;
    typedef logic [CHKPT_W-1:0] chkpt_id_t;
    // One extra bit so a completely full stack (NUM_CHKPT) is representable.
    typedef logic [CHKPT_W:0]   chkpt_cnt_t;

    typedef phys_reg_idx_t [ARCH_REG_SZ-1:0] map_table_t;

    typedef struct packed {
        logic          valid;
        phys_reg_idx_t reg_idx;
    } free_list_packet_t;

    // Reset mapping: every architectural register starts on its own physical tag.
    function automatic map_table_t identity_map();
        map_table_t m;
        for (int i = 0; i < ARCH_REG_SZ; i++) begin
            m[i] = phys_reg_idx_t'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/map_chkpt_stack.sv
// Circular stack of rename-map checkpoints used for early branch recovery.
// head is the oldest live checkpoint, tail is the next slot to be written.
// NUM_CHKPT is a power of two so the pointers wrap by plain overflow.
// Debug pointer outputs exist only when MAP_TABLE_DEBUG_EN is defined.
module map_chkpt_stack
    import map_table_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       save,
    input  map_table_t save_map,
    input  logic       free,
    input  logic       restore,
    input  chkpt_id_t  restore_id,
    output map_table_t restore_map,
    output chkpt_id_t  save_id,
    output logic       full
`ifdef MAP_TABLE_DEBUG_EN
    ,
    output chkpt_id_t  debug_head,
    output chkpt_id_t  debug_tail,
    output chkpt_cnt_t debug_count
`endif
);

    map_table_t chkpt_q [NUM_CHKPT];
    chkpt_id_t  head_q;
    chkpt_id_t  tail_q;
    chkpt_cnt_t count_q;

    chkpt_id_t  head_next;
    chkpt_id_t  tail_next;
    chkpt_cnt_t count_next;
    logic       do_free;
    logic       do_save;

    assign full        = (count_q == chkpt_cnt_t'(NUM_CHKPT));
    assign save_id     = tail_q;
    assign restore_map = chkpt_q[restore_id];

    // Pointer/count update: free is applied first, then a restore overrides tail/count.
    always_comb begin
        do_free    = free && (count_q != '0);
        do_save    = 1'b0;
        head_next  = head_q + chkpt_id_t'(do_free);
        tail_next  = tail_q;
        count_next = count_q;
        if (restore) begin
            // Restored checkpoint and everything younger are released.
            tail_next  = restore_id;
            count_next = chkpt_cnt_t'(chkpt_id_t'(restore_id - head_next));
        end else begin
            do_save    = save && !full;
            tail_next  = tail_q + chkpt_id_t'(do_save);
            count_next = count_q + chkpt_cnt_t'(do_save) - chkpt_cnt_t'(do_free);
        end
    end

    // Pointer, count and checkpoint storage registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_CHKPT; i++) begin
                chkpt_q[i] <= '0;
            end
        end else begin
            head_q  <= head_next;
            tail_q  <= tail_next;
            count_q <= count_next;
            if (do_save) begin
                chkpt_q[tail_q] <= save_map;
            end
        end
    end

`ifdef MAP_TABLE_DEBUG_EN
    assign debug_head  = head_q;
    assign debug_tail  = tail_q;
    assign debug_count = count_q;
`endif

endmodule

// File: rtl/map_table.sv
// N-wide rename map table: same-cycle source/dest renaming with intra-group
// forwarding, per-physical-register ready bits fed by the CDB, and a
// checkpoint stack for branch recovery.
// Defining MAP_TABLE_DEBUG_EN adds debug_* state outputs and simulation checks.
module map_table
    import map_table_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         rn_num,
    input  logic [N-1:0][ARCH_W-1:0] rn_dest,
    input  logic [N-1:0][ARCH_W-1:0] rn_src1,
    input  logic [N-1:0][ARCH_W-1:0] rn_src2,
    input  free_list_packet_t [N-1:0] fl_reg,
    output logic [CNT_W-1:0]         fl_rd_num,
    output logic [N-1:0][PHYS_W-1:0] rn_src1_phys,
    output logic [N-1:0][PHYS_W-1:0] rn_src2_phys,
    output logic [N-1:0]             rn_src1_rdy,
    output logic [N-1:0]             rn_src2_rdy,
    output logic [N-1:0][PHYS_W-1:0] rn_dest_phys,
    output logic [N-1:0][PHYS_W-1:0] rn_told,
    input  logic [N-1:0]             cdb_valid,
    input  logic [N-1:0][PHYS_W-1:0] cdb_tag,
    input  logic                     br_save,
    input  logic [SLOT_W-1:0]        br_save_slot,
    output logic [CHKPT_W-1:0]       br_save_id,
    input  logic                     br_en,
    input  logic [CHKPT_W-1:0]       br_restore_id,
    input  logic                     br_free,
    output logic                     chkpt_full
`ifdef MAP_TABLE_DEBUG_EN
    ,
    output map_table_t               debug_map,
    output logic [PHYS_REG_SZ-1:0]   debug_ready,
    output logic [CHKPT_W-1:0]       debug_chkpt_head,
    output logic [CHKPT_W-1:0]       debug_chkpt_tail,
    output logic [CHKPT_W:0]         debug_chkpt_count
`endif
);

    map_table_t              map_q;
    map_table_t              work_map;
    map_table_t              save_map;
    map_table_t              restore_map;
    logic [PHYS_REG_SZ-1:0]  ready_q;
    logic [PHYS_REG_SZ-1:0]  ready_next;
    logic [PHYS_REG_SZ-1:0]  cdb_set;
    logic [PHYS_REG_SZ-1:0]  ready_eff;
    logic [ARCH_REG_SZ-1:0]  written;
    logic [N-1:0]            alloc_valid;
    logic [CNT_W-1:0]        alloc_cnt;
    phys_reg_idx_t           new_tag;
    logic [N-1:0]            fl_valid_bits;

    // Tags broadcast on the CDB this cycle, used both for bypass and for the ready update.
    always_comb begin
        cdb_set = '0;
        for (int c = 0; c < N; c++) begin
            if (cdb_valid[c]) begin
                cdb_set[cdb_tag[c]] = 1'b1;
            end
        end
    end

    assign ready_eff = ready_q | cdb_set;

    // Rename walk: work_map accumulates each slot's new mapping so younger slots
    // see older slots' tags; written marks arch regs produced inside this group.
    always_comb begin
        work_map     = map_q;
        save_map     = map_q;
        written      = '0;
        alloc_cnt    = '0;
        alloc_valid  = '0;
        new_tag      = '0;
        rn_src1_phys = '0;
        rn_src2_phys = '0;
        rn_src1_rdy  = '0;
        rn_src2_rdy  = '0;
        rn_dest_phys = '0;
        rn_told      = '0;
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < rn_num) begin
                if (rn_src1[i] != '0) begin
                    rn_src1_phys[i] = work_map[rn_src1[i]];
                    rn_src1_rdy[i]  = !written[rn_src1[i]] && ready_eff[work_map[rn_src1[i]]];
                end else begin
                    rn_src1_rdy[i]  = 1'b1;
                end
                if (rn_src2[i] != '0) begin
                    rn_src2_phys[i] = work_map[rn_src2[i]];
                    rn_src2_rdy[i]  = !written[rn_src2[i]] && ready_eff[work_map[rn_src2[i]]];
                end else begin
                    rn_src2_rdy[i]  = 1'b1;
                end
                if (rn_dest[i] != '0) begin
                    new_tag = '0;
                    for (int k = 0; k < N; k++) begin
                        if (CNT_W'(k) == alloc_cnt) begin
                            new_tag = fl_reg[k].reg_idx;
                        end
                    end
                    rn_told[i]            = work_map[rn_dest[i]];
                    rn_dest_phys[i]       = new_tag;
                    alloc_valid[i]        = 1'b1;
                    work_map[rn_dest[i]]  = new_tag;
                    written[rn_dest[i]]   = 1'b1;
                    alloc_cnt             = alloc_cnt + CNT_W'(1);
                end
            end
            if (SLOT_W'(i) == br_save_slot) begin
                save_map = work_map;
            end
        end
    end

    assign fl_rd_num = alloc_cnt;

    // Ready update: CDB sets, fresh allocations clear (clear wins on the same tag).
    always_comb begin
        ready_next = ready_q | cdb_set;
        if (!br_en) begin
            for (int i = 0; i < N; i++) begin
                if (alloc_valid[i]) begin
                    ready_next[rn_dest_phys[i]] = 1'b0;
                end
            end
        end
    end

    // Map and ready registers; a mispredict restores the map and drops this cycle's renames.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            map_q   <= identity_map();
            ready_q <= '1;
        end else begin
            map_q   <= br_en ? restore_map : work_map;
            ready_q <= ready_next;
        end
    end

    map_chkpt_stack u_chkpt (
        .clock       (clock),
        .reset       (reset),
        .save        (br_save),
        .save_map    (save_map),
        .free        (br_free),
        .restore     (br_en),
        .restore_id  (br_restore_id),
        .restore_map (restore_map),
        .save_id     (br_save_id),
        .full        (chkpt_full)
`ifdef MAP_TABLE_DEBUG_EN
        ,
        .debug_head  (debug_chkpt_head),
        .debug_tail  (debug_chkpt_tail),
        .debug_count (debug_chkpt_count)
`endif
    );

    // Collect free-list valid flags; only the debug checks consume them.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            fl_valid_bits[k] = fl_reg[k].valid;
        end
    end

`ifdef MAP_TABLE_DEBUG_EN
    chkpt_id_t  head_af;
    chkpt_cnt_t count_af;
    logic       free_live;

    assign debug_map   = map_q;
    assign debug_ready = ready_q;
    assign free_live   = br_free && (debug_chkpt_count != '0);
    assign head_af     = debug_chkpt_head + chkpt_id_t'(free_live);
    assign count_af    = debug_chkpt_count - chkpt_cnt_t'(free_live);

    restore_id_live: assert property (@(posedge clock) disable iff (!reset)
        br_en |-> (chkpt_cnt_t'(chkpt_id_t'(br_restore_id - head_af)) < count_af));

    for (genvar k = 0; k < N; k++) begin : g_fl_valid_chk
        fl_reg_valid: assert property (@(posedge clock) disable iff (!reset)
            (CNT_W'(k) < fl_rd_num) |-> fl_valid_bits[k]);
    end
`else
    logic unused_fl_valid;
    assign unused_fl_valid = ^fl_valid_bits;
`endif

endmodule

// File: tb/tb_map_table.sv
// Randomized self-checking bench for map_table with a behavioural reference model.
module tb_map_table;
    import map_table_pkg::*;

    logic                     clock;
    logic                     reset;
    logic [CNT_W-1:0]         rn_num;
    logic [N-1:0][ARCH_W-1:0] rn_dest;
    logic [N-1:0][ARCH_W-1:0] rn_src1;
    logic [N-1:0][ARCH_W-1:0] rn_src2;
    free_list_packet_t [N-1:0] fl_reg;
    logic [CNT_W-1:0]         fl_rd_num;
    logic [N-1:0][PHYS_W-1:0] rn_src1_phys;
    logic [N-1:0][PHYS_W-1:0] rn_src2_phys;
    logic [N-1:0]             rn_src1_rdy;
    logic [N-1:0]             rn_src2_rdy;
    logic [N-1:0][PHYS_W-1:0] rn_dest_phys;
    logic [N-1:0][PHYS_W-1:0] rn_told;
    logic [N-1:0]             cdb_valid;
    logic [N-1:0][PHYS_W-1:0] cdb_tag;
    logic                     br_save;
    logic [SLOT_W-1:0]        br_save_slot;
    logic [CHKPT_W-1:0]       br_save_id;
    logic                     br_en;
    logic [CHKPT_W-1:0]       br_restore_id;
    logic                     br_free;
    logic                     chkpt_full;
`ifdef MAP_TABLE_DEBUG_EN
    map_table_t               debug_map;
    logic [PHYS_REG_SZ-1:0]   debug_ready;
    logic [CHKPT_W-1:0]       debug_chkpt_head;
    logic [CHKPT_W-1:0]       debug_chkpt_tail;
    logic [CHKPT_W:0]         debug_chkpt_count;
`endif

    map_table dut (
        .clock         (clock),
        .reset         (reset),
        .rn_num        (rn_num),
        .rn_dest       (rn_dest),
        .rn_src1       (rn_src1),
        .rn_src2       (rn_src2),
        .fl_reg        (fl_reg),
        .fl_rd_num     (fl_rd_num),
        .rn_src1_phys  (rn_src1_phys),
        .rn_src2_phys  (rn_src2_phys),
        .rn_src1_rdy   (rn_src1_rdy),
        .rn_src2_rdy   (rn_src2_rdy),
        .rn_dest_phys  (rn_dest_phys),
        .rn_told       (rn_told),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .br_save       (br_save),
        .br_save_slot  (br_save_slot),
        .br_save_id    (br_save_id),
        .br_en         (br_en),
        .br_restore_id (br_restore_id),
        .br_free       (br_free),
        .chkpt_full    (chkpt_full)
`ifdef MAP_TABLE_DEBUG_EN
        ,
        .debug_map         (debug_map),
        .debug_ready       (debug_ready),
        .debug_chkpt_head  (debug_chkpt_head),
        .debug_chkpt_tail  (debug_chkpt_tail),
        .debug_chkpt_count (debug_chkpt_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    int  map_m   [ARCH_REG_SZ];
    bit  ready_m [PHYS_REG_SZ];
    int  chk_m   [NUM_CHKPT][ARCH_REG_SZ];
    int  head_m, tail_m, cnt_m;
    int  exp_tag [N];
    int  checks, errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < ARCH_REG_SZ; a++) map_m[a] = a;
        for (int p = 0; p < PHYS_REG_SZ; p++) ready_m[p] = 1'b1;
        for (int c = 0; c < NUM_CHKPT; c++)
            for (int a = 0; a < ARCH_REG_SZ; a++) chk_m[c][a] = 0;
        head_m = 0;
        tail_m = 0;
        cnt_m  = 0;
    endtask

    function automatic bit cdb_hit(input int tag);
        bit hit = 1'b0;
        for (int c = 0; c < N; c++)
            if (cdb_valid[c] && int'(cdb_tag[c]) == tag) hit = 1'b1;
        return hit;
    endfunction

    // Source/Told lookup: nearest older producer in the group, else the committed map.
    task automatic lookup(input int s, input int i, output int tag, output bit rdy);
        bit found = 1'b0;
        tag = 0;
        rdy = 1'b1;
        if (s != 0) begin
            for (int j = i - 1; j >= 0; j--) begin
                if (!found && int'(rn_dest[j]) == s) begin
                    found = 1'b1;
                    tag   = exp_tag[j];
                    rdy   = 1'b0;
                end
            end
            if (!found) begin
                tag = map_m[s];
                rdy = ready_m[tag] || cdb_hit(tag);
            end
        end
    endtask

    task automatic check_outputs();
        int k = 0;
        int t;
        bit r;
        for (int i = 0; i < N; i++) begin
            exp_tag[i] = 0;
            if (i < int'(rn_num) && rn_dest[i] != '0) begin
                exp_tag[i] = int'(fl_reg[k].reg_idx);
                k++;
            end
        end
        check("fl_rd_num", fl_rd_num, k);
        for (int i = 0; i < N; i++) begin
            if (i >= int'(rn_num)) begin
                check($sformatf("idle_slot[%0d]", i),
                      {rn_src1_phys[i], rn_src2_phys[i], rn_src1_rdy[i], rn_src2_rdy[i],
                       rn_dest_phys[i], rn_told[i]}, 0);
            end else begin
                lookup(int'(rn_src1[i]), i, t, r);
                check($sformatf("src1_phys[%0d]", i), rn_src1_phys[i], t);
                check($sformatf("src1_rdy[%0d]", i), rn_src1_rdy[i], r);
                lookup(int'(rn_src2[i]), i, t, r);
                check($sformatf("src2_phys[%0d]", i), rn_src2_phys[i], t);
                check($sformatf("src2_rdy[%0d]", i), rn_src2_rdy[i], r);
                if (rn_dest[i] == '0) begin
                    check($sformatf("dest_phys[%0d]", i), rn_dest_phys[i], 0);
                    check($sformatf("told[%0d]", i), rn_told[i], 0);
                end else begin
                    lookup(int'(rn_dest[i]), i, t, r);
                    check($sformatf("dest_phys[%0d]", i), rn_dest_phys[i], exp_tag[i]);
                    check($sformatf("told[%0d]", i), rn_told[i], t);
                end
            end
        end
        check("chkpt_full", chkpt_full, cnt_m == NUM_CHKPT);
        check("br_save_id", br_save_id, tail_m);
    endtask

    // Clock-edge effect of the current inputs on the model.
    task automatic model_update();
        int  new_map [ARCH_REG_SZ];
        int  snap    [ARCH_REG_SZ];
        int  k = 0;
        bit  do_free, do_save;
        do_free = br_free && cnt_m > 0;
        for (int c = 0; c < N; c++)
            if (cdb_valid[c]) ready_m[cdb_tag[c]] = 1'b1;
        if (br_en) begin
            if (do_free) begin
                head_m = (head_m + 1) % NUM_CHKPT;
                cnt_m--;
            end
            map_m  = chk_m[br_restore_id];
            tail_m = int'(br_restore_id);
            cnt_m  = (int'(br_restore_id) - head_m + NUM_CHKPT) % NUM_CHKPT;
        end else begin
            new_map = map_m;
            snap    = map_m;
            for (int i = 0; i < N; i++) begin
                if (i < int'(rn_num) && rn_dest[i] != '0) begin
                    new_map[rn_dest[i]] = int'(fl_reg[k].reg_idx);
                    ready_m[fl_reg[k].reg_idx] = 1'b0;
                    k++;
                end
                if (i == int'(br_save_slot)) snap = new_map;
            end
            do_save = br_save && cnt_m < NUM_CHKPT;
            if (do_save) begin
                chk_m[tail_m] = snap;
                tail_m = (tail_m + 1) % NUM_CHKPT;
                cnt_m++;
            end
            if (do_free) begin
                head_m = (head_m + 1) % NUM_CHKPT;
                cnt_m--;
            end
            map_m = new_map;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        rn_num        = '0;
        rn_dest       = '0;
        rn_src1       = '0;
        rn_src2       = '0;
        for (int i = 0; i < N; i++) fl_reg[i] = '{valid: 1'b1, reg_idx: '0};
        cdb_valid     = '0;
        cdb_tag       = '0;
        br_save       = 1'b0;
        br_save_slot  = '0;
        br_en         = 1'b0;
        br_restore_id = '0;
        br_free       = 1'b0;
    endtask

    // Inputs are driven just after a falling edge; this checks, clocks, and returns at the next falling edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clock);
        #1;
        model_update();
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic drive_random();
        int ha, ca;
        set_idle();
        rn_num = CNT_W'($urandom_range(0, N));
        for (int i = 0; i < N; i++) begin
            rn_dest[i]   = ARCH_W'($urandom_range(0, 7));
            rn_src1[i]   = ARCH_W'($urandom_range(0, 7));
            rn_src2[i]   = ARCH_W'($urandom_range(0, 7));
            fl_reg[i]    = '{valid: 1'b1, reg_idx: PHYS_W'($urandom_range(1, PHYS_REG_SZ - 1))};
            cdb_valid[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                cdb_tag[i] = PHYS_W'(map_m[$urandom_range(0, 7)]);
            else
                cdb_tag[i] = PHYS_W'($urandom_range(0, PHYS_REG_SZ - 1));
        end
        br_free = (cnt_m > 0) && ($urandom_range(0, 3) == 0);
        ha = (head_m + (br_free ? 1 : 0)) % NUM_CHKPT;
        ca = cnt_m - (br_free ? 1 : 0);
        br_en = (ca > 0) && ($urandom_range(0, 5) == 0);
        if (br_en)
            br_restore_id = CHKPT_W'((ha + $urandom_range(0, ca - 1)) % NUM_CHKPT);
        else
            br_restore_id = CHKPT_W'($urandom_range(0, NUM_CHKPT - 1));
        br_save      = ($urandom_range(0, 2) == 0) && !(cnt_m == NUM_CHKPT && br_free);
        br_save_slot = SLOT_W'($urandom_range(0, N - 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        set_idle();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        // reset state
        #1;
        check("reset_full", chkpt_full, 0);
        check("reset_save_id", br_save_id, 0);
        check("reset_fl_rd_num", fl_rd_num, 0);
        check_outputs();
        @(negedge clock);
        reset = 1'b1;

        // basic two-wide rename
        rn_num = 2;
        rn_dest[0] = 1; rn_dest[1] = 2;
        rn_src1[0] = 1;
        fl_reg[0].reg_idx = 32; fl_reg[1].reg_idx = 33;
        #1;
        check("t1_src1_phys", rn_src1_phys[0], 1);
        check("t1_src1_rdy", rn_src1_rdy[0], 1);
        check("t1_dest0", rn_dest_phys[0], 32);
        check("t1_dest1", rn_dest_phys[1], 33);
        check("t1_told0", rn_told[0], 1);
        check("t1_told1", rn_told[1], 2);
        check("t1_fl_rd_num", fl_rd_num, 2);
        step();

        // intra-group forwarding and duplicate dest
        set_idle();
        rn_num = 2;
        rn_dest[0] = 5; rn_dest[1] = 5; rn_src1[1] = 5;
        fl_reg[0].reg_idx = 40; fl_reg[1].reg_idx = 41;
        #1;
        check("t2_fwd_phys", rn_src1_phys[1], 40);
        check("t2_fwd_rdy", rn_src1_rdy[1], 0);
        check("t2_told1", rn_told[1], 40);
        check("t2_dest1", rn_dest_phys[1], 41);
        step();
        set_idle();
        rn_num = 1; rn_src1[0] = 5;
        #1;
        check("t2_youngest_wins", rn_src1_phys[0], 41);
        check("t2_unready", rn_src1_rdy[0], 0);
        step();

        // same-cycle CDB bypass, then ready bit latched
        set_idle();
        rn_num = 1; rn_src1[0] = 5;
        cdb_valid[0] = 1'b1; cdb_tag[0] = 41;
        #1;
        check("t3_cdb_bypass", rn_src1_rdy[0], 1);
        step();
        set_idle();
        rn_num = 1; rn_src1[0] = 5;
        #1;
        check("t3_ready_latched", rn_src1_rdy[0], 1);
        step();

        // checkpoint at slot 0, restore next cycle with a rename that must be dropped
        do_reset();
        rn_num = 2;
        rn_dest[0] = 3; rn_dest[1] = 3;
        fl_reg[0].reg_idx = 50; fl_reg[1].reg_idx = 51;
        br_save = 1'b1; br_save_slot = 0;
        step();
        set_idle();
        rn_num = 2;
        rn_dest[0] = 3; rn_dest[1] = 4;
        fl_reg[0].reg_idx = 60; fl_reg[1].reg_idx = 61;
        br_en = 1'b1; br_restore_id = 0;
        step();
        set_idle();
        rn_num = 2; rn_src1[0] = 3; rn_src1[1] = 4;
        #1;
        check("t4_restored_r3", rn_src1_phys[0], 50);
        check("t4_r4_untouched", rn_src1_phys[1], 4);
        check("t4_count_zero_full", chkpt_full, 0);
        check("t4_tail", br_save_id, 0);
        step();

        // fill the stack, overflow save, free, wrap
        do_reset();
        for (int t = 0; t < NUM_CHKPT; t++) begin
            set_idle();
            br_save = 1'b1;
            #1;
            check("t5_save_id", br_save_id, t);
            step();
        end
        set_idle();
        br_save = 1'b1;
        #1;
        check("t5_full", chkpt_full, 1);
        step();
        set_idle();
        br_free = 1'b1;
        step();
        set_idle();
        br_save = 1'b1;
        #1;
        check("t5_not_full", chkpt_full, 0);
        check("t5_wrap_id", br_save_id, 0);
        step();
        set_idle();
        br_en = 1'b1; br_restore_id = 1;
        step();
        set_idle();
        #1;
        check("t5_after_restore", br_save_id, 1);
        step();

        // dest r0 consumes no free register
        do_reset();
        rn_num = 2;
        rn_dest[0] = 0; rn_dest[1] = 7;
        fl_reg[0].reg_idx = 60; fl_reg[1].reg_idx = 61;
        #1;
        check("t6_fl_rd_num", fl_rd_num, 1);
        check("t6_dest1", rn_dest_phys[1], 60);
        check("t6_told0", rn_told[0], 0);
        check("t6_dest0", rn_dest_phys[0], 0);
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive_random();
            step();
        end

        // asynchronous reset mid-stream
        drive_random();
        #3;
        reset = 1'b0;
        model_reset();
        set_idle();
        rn_num = 1; rn_src1[0] = 5; rn_src2[0] = 3;
        #1;
        check("t7_reset_map", rn_src1_phys[0], 5);
        check("t7_reset_rdy", rn_src1_rdy[0], 1);
        check("t7_reset_full", chkpt_full, 0);
        check("t7_reset_tail", br_save_id, 0);
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 100; n++) begin
            drive_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
